// File: rtl/key_seq_ctrl.sv
// rtl/key_seq_ctrl.sv - serial key loader and run-budget sequencer for a locked DUT FSM
module key_seq_ctrl #(
  parameter int KEY_W = 8,
  parameter int CNT_W = 16,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             key_valid,
  input  logic             key_bit,
  input  logic [CNT_W-1:0] run_cycles,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt
);

  // Bit counter only ever holds 0..KEY_W-1; idle timer only ever reaches TMO.
  localparam int BCNT_W = $clog2(KEY_W + 1);
  localparam int TMR_W  = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    APPLY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   shift_q, shift_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               err_q, err_d;

  // State and datapath registers; rst clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcnt_q      <= '0;
      tmr_q       <= '0;
      run_q       <= '0;
      key_out_q   <= '0;
      cycle_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      tmr_q       <= tmr_d;
      run_q       <= run_d;
      key_out_q   <= key_out_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath update; abort overrides every other event.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcnt_d      = bcnt_q;
    tmr_d       = tmr_q;
    run_d       = run_q;
    key_out_d   = key_out_q;
    cycle_cnt_d = cycle_cnt_q;
    err_d       = err_q;

    if (abort) begin
      state_d   = IDLE;
      key_out_d = '0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = LOAD;
            shift_d = '0;
            bcnt_d  = '0;
            tmr_d   = '0;
            run_d   = run_cycles;
            err_d   = 1'b0;
          end
        end

        LOAD: begin
          if (key_valid) begin
            // A bit arriving on the would-be timeout cycle still counts.
            shift_d = KEY_W'({shift_q, key_bit});
            tmr_d   = '0;
            if (bcnt_q == BCNT_W'(KEY_W - 1)) begin
              state_d = APPLY;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TMR_W'(TMO - 1)) begin
              state_d = DONE;
              err_d   = 1'b1;
            end
          end
        end

        APPLY: begin
          key_out_d   = shift_q;
          cycle_cnt_d = '0;
          state_d     = RUN;
        end

        RUN: begin
          // A zero budget means run until abort, with a saturating counter.
          if ((run_q != '0) && (cycle_cnt_q == run_q - CNT_W'(1))) begin
            state_d = DONE;
          end else if (cycle_cnt_q != {CNT_W{1'b1}}) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs come from registers or from the state alone.
  always_comb begin
    key_ready = (state_q == LOAD);
    dut_rst   = (state_q != RUN);
    busy      = (state_q == LOAD) || (state_q == APPLY) || (state_q == RUN);
    done      = (state_q == DONE);
    err       = err_q;
    key_out   = key_out_q;
    cycle_cnt = cycle_cnt_q;
  end

endmodule

// File: tb/tb_key_seq_ctrl.sv
// tb/tb_key_seq_ctrl.sv - directed self-checking bench for key_seq_ctrl
module tb_key_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        key_valid;
  logic        key_bit;
  logic [15:0] run_cycles;
  logic        key_ready;
  logic [7:0]  key_out;
  logic        dut_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  key_seq_ctrl #(.KEY_W(8), .CNT_W(16), .TMO(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .run_cycles (run_cycles),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .dut_rst    (dut_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [15:0] rc);
    start      = 1'b1;
    run_cycles = rc;
    tick();
    start      = 1'b0;
  endtask

  // Sends the top nbits of k, MSB first, with gap idle cycles between bits.
  task automatic send_bits(input logic [7:0] k, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      key_valid = 1'b1;
      key_bit   = k[7-i];
      tick();
      key_valid = 1'b0;
      key_bit   = 1'b0;
      if (i != nbits - 1) repeat (gap) tick();
    end
  endtask

  initial begin
    int n;
    logic low_seen;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    key_valid = 1'b0; key_bit = 1'b0; run_cycles = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_key_out", key_out, 0);
    check_eq("rst_key_ready", key_ready, 0);
    check_eq("rst_dut_rst", dut_rst, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_cycle_cnt", cycle_cnt, 0);
    rst = 1'b0;
    repeat (3) tick();
    check_eq("idle_hold_busy", busy, 0);

    // Normal session: key B2, budget 5, start pulsed during RUN is ignored.
    begin_session(16'd5);
    check_eq("norm_key_ready", key_ready, 1);
    check_eq("norm_busy", busy, 1);
    send_bits(8'hB2, 8, 0);
    check_eq("norm_apply_ready", key_ready, 0);
    check_eq("norm_apply_dut_rst", dut_rst, 1);
    tick();
    check_eq("norm_key_out", key_out, 32'hB2);
    check_eq("norm_run_cnt0", cycle_cnt, 0);
    start = 1'b1;
    n = 0;
    while (!dut_rst && n < 50) begin
      n++;
      tick();
      start = 1'b0;
    end
    start = 1'b0;
    check_eq("norm_run_len", n, 5);
    check_eq("norm_final_cnt", cycle_cnt, 4);
    check_eq("norm_done", done, 1);
    check_eq("norm_err", err, 0);
    check_eq("norm_busy_end", busy, 0);

    // Async reset in LOAD after 4 bits, then a fresh start needs all 8 bits.
    begin_session(16'd2);
    send_bits(8'hB2, 4, 0);
    check_eq("ar_pre_key_out", key_out, 32'hB2);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_key_out", key_out, 0);
    check_eq("ar_key_ready", key_ready, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_dut_rst", dut_rst, 1);
    check_eq("ar_done", done, 0);
    #1 rst = 1'b0;
    repeat (2) tick();
    check_eq("ar_stay_idle", busy, 0);
    begin_session(16'd2);
    send_bits(8'hB2, 7, 0);
    check_eq("ar_7bits_ready", key_ready, 1);
    send_bits(8'h00, 1, 0);
    check_eq("ar_8bits_ready", key_ready, 0);
    tick();
    check_eq("ar_key_out_new", key_out, 32'hB2);
    repeat (2) tick();
    check_eq("ar_done_end", done, 1);

    // Timeout: 3 bits then 255 idle cycles.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("tmo_pre_key_out", key_out, 0);
    check_eq("tmo_pre_done", done, 0);
    begin_session(16'd3);
    send_bits(8'hE0, 3, 0);
    low_seen = 1'b0;
    repeat (254) begin
      if (!dut_rst) low_seen = 1'b1;
      tick();
    end
    check_eq("tmo_254_busy", busy, 1);
    check_eq("tmo_254_err", err, 0);
    tick();
    if (!dut_rst) low_seen = 1'b1;
    check_eq("tmo_done", done, 1);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_key_out", key_out, 0);
    check_eq("tmo_dut_rst_low_seen", low_seen, 0);

    // Gapped key with 3 idle cycles between bits.
    begin_session(16'd2);
    check_eq("gap_err_cleared", err, 0);
    send_bits(8'hB2, 8, 3);
    tick();
    check_eq("gap_key_out", key_out, 32'hB2);
    repeat (2) tick();
    check_eq("gap_done", done, 1);
    check_eq("gap_err", err, 0);

    // Bit arriving on the timeout cycle is accepted.
    begin_session(16'd1);
    repeat (254) tick();
    check_eq("edge_still_load", key_ready, 1);
    send_bits(8'hA5, 8, 0);
    check_eq("edge_err", err, 0);
    check_eq("edge_apply_ready", key_ready, 0);
    tick();
    check_eq("edge_key_out", key_out, 32'hA5);
    tick();
    check_eq("edge_done", done, 1);
    check_eq("edge_err_end", err, 0);

    // Abort and start together in DONE: abort wins.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_eq("abst_done", done, 0);
    check_eq("abst_busy", busy, 0);
    check_eq("abst_key_out", key_out, 0);
    tick();
    check_eq("abst_idle_hold", busy, 0);

    // Abort in RUN at cycle_cnt = 10.
    begin_session(16'd100);
    send_bits(8'hB2, 8, 0);
    tick();
    repeat (10) tick();
    check_eq("abrun_cnt", cycle_cnt, 10);
    check_eq("abrun_dut_rst_pre", dut_rst, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abrun_busy", busy, 0);
    check_eq("abrun_key_out", key_out, 0);
    check_eq("abrun_dut_rst", dut_rst, 1);
    check_eq("abrun_done", done, 0);
    check_eq("abrun_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
